// File: rtl/in_channel_server.sv
// Program input channel: host loads words over valid/ready, then the channel is sealed and the program pops words / reads remaining count.
// Latency: one cycle from rd_en to rd_data/rd_valid; size and state update on the same edge.
// Backpressure: load_ready drops once NIn words are held or the channel leaves LOAD; optional replay via rewind when IN_CHANNEL_REWIND_EN is defined.
module in_channel_server #(
  parameter int MemoryElementWidth = 12,
  parameter int NIn                = 8,
  parameter int PtrWidth           = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [MemoryElementWidth-1:0] load_data,
  input  logic                          load_last,
  input  logic                          seal,
  input  logic                          rd_en,
`ifdef IN_CHANNEL_REWIND_EN
  input  logic                          rewind,
`endif
  output logic [MemoryElementWidth-1:0] rd_data,
  output logic                          rd_valid,
  output logic [MemoryElementWidth-1:0] size,
  output logic                          underrun,
  output logic [1:0]                    state
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_SERVE   = 2'd1,
    ST_DRAINED = 2'd2
  } state_t;

  localparam logic [MemoryElementWidth-1:0] NInW = MemoryElementWidth'(NIn);

  // Storage is indexed over the full pointer range so pointer reads never need narrowing.
  logic [MemoryElementWidth-1:0] r_mem [0:(1<<PtrWidth)-1];

  state_t                        r_state,    w_state_nxt;
  logic [PtrWidth-1:0]           r_wptr,     w_wptr_nxt;
  logic [PtrWidth-1:0]           r_rptr,     w_rptr_nxt;
  logic [MemoryElementWidth-1:0] r_loaded,   w_loaded_nxt;
  logic [MemoryElementWidth-1:0] r_size,     w_size_nxt;
  logic [MemoryElementWidth-1:0] r_rd_data,  w_rd_data_nxt;
  logic                          r_rd_valid, w_rd_valid_nxt;
  logic                          r_underrun, w_underrun_nxt;

  logic w_load_ready;
  logic w_accept;
  logic w_rewind;

`ifdef IN_CHANNEL_REWIND_EN
  assign w_rewind = rewind;
`else
  assign w_rewind = 1'b0;
`endif

  assign w_load_ready = (r_state == ST_LOAD) && (r_loaded < NInW);
  assign w_accept     = load_valid && w_load_ready;

  assign load_ready = w_load_ready;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign size       = r_size;
  assign underrun   = r_underrun;
  assign state      = r_state;

  // Next-state and datapath decisions for load, seal, pop, underrun and rewind.
  always_comb begin
    w_state_nxt    = r_state;
    w_wptr_nxt     = r_wptr;
    w_rptr_nxt     = r_rptr;
    w_loaded_nxt   = r_loaded;
    w_size_nxt     = r_size;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    w_underrun_nxt = r_underrun;

    case (r_state)
      ST_LOAD: begin
        if (w_accept) begin
          w_wptr_nxt   = r_wptr + PtrWidth'(1);
          w_loaded_nxt = r_loaded + MemoryElementWidth'(1);
          w_size_nxt   = r_size + MemoryElementWidth'(1);
          // A seal arriving with a word still takes the word first.
          if (load_last || seal || (w_loaded_nxt == NInW)) begin
            w_state_nxt = ST_SERVE;
          end
        end else if (seal) begin
          w_state_nxt = (r_loaded != '0) ? ST_SERVE : ST_DRAINED;
        end
      end

      ST_SERVE, ST_DRAINED: begin
        if (w_rewind) begin
          // Rewind takes priority over a pop requested in the same cycle.
          w_rptr_nxt  = '0;
          w_size_nxt  = r_loaded;
          w_state_nxt = (r_loaded != '0) ? ST_SERVE : ST_DRAINED;
        end else if (rd_en) begin
          if (r_size != '0) begin
            w_rd_data_nxt  = r_mem[r_rptr];
            w_rd_valid_nxt = 1'b1;
            w_rptr_nxt     = r_rptr + PtrWidth'(1);
            w_size_nxt     = r_size - MemoryElementWidth'(1);
            if (r_size == MemoryElementWidth'(1)) begin
              w_state_nxt = ST_DRAINED;
            end
          end else begin
            w_underrun_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_LOAD;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_loaded   <= '0;
      r_size     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_loaded   <= w_loaded_nxt;
      r_size     <= w_size_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  // Word storage: written on accepted loads, never cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset && w_accept) begin
      r_mem[r_wptr] <= load_data;
    end
  end

endmodule

// File: doc/in_channel_server.md
Name: in_channel_server

Overview:
- Producer end of the program input channel. Serves the `in` and `inSize` operations that generated test programs execute.
- A testbench or host loads words through a valid/ready port. The channel is then sealed, and the executing program pops words one at a time and queries the remaining count.
- Replaces the hard-coded input-memory preload, so one program image can run against varying input streams.

Parameters:
- MemoryElementWidth, 12, width of each channel word and of the size output.
- NIn, 8, channel depth in words; must satisfy 1 <= NIn < 2^MemoryElementWidth.
- PtrWidth, 4, width of internal read/write pointers; must satisfy 2^PtrWidth > NIn.

Ports:
- clock  input  1  driving clock
- reset  input  1  synchronous, active-high
- load_valid  input  1  host offers load_data this cycle
- load_ready  output  1  channel accepts a word this cycle
- load_data  input  MemoryElementWidth  word to append
- load_last  input  1  with load_valid: this is the final word; seal after accepting it
- seal  input  1  seal the channel with no further words (legal in LOAD only)
- rd_en  input  1  program `in` request, single-cycle pulse
- rd_data  output  MemoryElementWidth  popped word, registered
- rd_valid  output  1  rd_data updated this cycle (one-cycle pulse)
- size  output  MemoryElementWidth  unread words remaining (`inSize` result), registered
- underrun  output  1  sticky: a read was attempted on an empty sealed channel
- state  output  2  0 LOAD, 1 SERVE, 2 DRAINED (debug/verification)
- rewind  input  1  present only with the optional feature

Behaviour:
- Reset (sampled on posedge clock while reset=1):
  - state=LOAD, write and read pointers=0, size=0, loaded=0.
  - rd_data=0, rd_valid=0, underrun=0, load_ready=1.
  - Buffer contents are not cleared.
  - Reset asserted mid-operation aborts any load or read in the same cycle.
- LOAD state:
  - load_ready = (loaded < NIn), combinational from registered state.
  - Handshake: a word is accepted on a posedge with load_valid & load_ready. It is written at the write pointer; the pointer, loaded and size each increment by 1.
  - Transition to SERVE on any of:
    - the accept cycle where load_last=1;
    - the accept cycle that makes loaded==NIn (auto-seal);
    - a cycle with seal=1 and loaded>0.
  - seal=1 with loaded==0: go directly to DRAINED.
  - seal and an accepted word in the same cycle: the word is accepted, then the channel seals.
  - rd_en in LOAD is ignored: no rd_valid pulse, underrun unaffected.
- SERVE state:
  - load_ready=0; load_valid and seal are ignored.
  - rd_en with size>0: next edge loads rd_data from the buffer at the read pointer. The read pointer increments, size decrements, and rd_valid=1 for that cycle.
  - Read latency is one cycle.
  - If size becomes 0, transition to DRAINED on the same edge.
- DRAINED state:
  - load_ready=0.
  - rd_en: rd_valid stays 0, rd_data holds its last value, underrun set to 1 (sticky until reset).
  - The channel leaves DRAINED only on reset, or via rewind if the feature is present.
- rd_valid is 0 in every cycle without a successful pop.
- size always equals loaded minus words popped since seal or rewind. size never underflows.

Optional Feature:
- Macro IN_CHANNEL_REWIND_EN.
- Defined:
  - rewind port exists. A rewind pulse in SERVE or DRAINED sets read pointer=0, size=loaded and state=SERVE. If loaded==0, state=DRAINED.
  - underrun is not cleared by rewind.
  - rewind wins over a simultaneous rd_en: no pop that cycle.
  - rewind in LOAD is ignored.
  - Lets one loaded stream be replayed for repeated program runs without reloading.
- Undefined: the port is absent; the only exit from DRAINED is reset.

Test Plan:
1. Load 88, then 44 with load_last -> state=SERVE, size=2. rd_en -> next cycle rd_data=88, rd_valid=1, size=1. rd_en -> rd_data=44, size=0, state=DRAINED.
2. Offer 8 words 1..8 back-to-back, no load_last -> all accepted, load_ready=0 after the 8th, state=SERVE, size=8. Offered 9th word is not accepted.
3. From end of case 1, rd_en -> rd_valid=0, rd_data stays 44, underrun=1, size=0. A further rd_en -> underrun stays 1.
4. After reset, seal with no words -> state=DRAINED, size=0. rd_en -> underrun=1.
5. Load 5, 6, 7 sealed, pop one (size=2), assert reset mid-stream -> next cycle state=LOAD, size=0, load_ready=1, rd_valid=0, underrun=0.
6. With IN_CHANNEL_REWIND_EN: load 88, 44 sealed, pop both, rewind together with rd_en -> size=2, state=SERVE, no rd_valid. Next rd_en -> rd_data=88.
